// File: rtl/rv_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv_lsu_pkg
// Brief  : Shared types and helpers for the RV32 load/store unit: funct3
//          encodings, queue entry layout, alignment checks, store byte
//          masks and load extraction/extension.
// Rev    : 1.0 - initial release
// ============================================================================
package rv_lsu_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } rvLdOp_t;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } rvStOp_t;

    // Widest lane offset supported (64-bit bus -> 8 byte lanes).
    localparam int c_OFF_W_MAX = 3;

    // One outstanding access, remembered until its response returns.
    typedef struct packed {
        logic [4:0]             rd;
        logic [2:0]             fsel;
        logic [c_OFF_W_MAX-1:0] off;
        logic                   is_st;
    } lsuQEntry_t;

    // Natural alignment check on the two low address bits.
    function automatic logic get_misaligned(input logic [2:0] op, input logic is_st,
                                            input logic [1:0] addr);
        logic r;
        r = 1'b0;
        if (is_st) begin
            case (op)
                ST_SH:   r = addr[0];
                ST_SW:   r = (addr != 2'b00);
                default: r = 1'b0;
            endcase
        end else begin
            case (op)
                LD_LH, LD_LHU: r = addr[0];
                LD_LW:         r = (addr != 2'b00);
                default:       r = 1'b0;
            endcase
        end
        return r;
    endfunction

    // funct3 values with no defined load/store meaning.
    function automatic logic get_illegal(input logic [2:0] op, input logic is_st);
        if (is_st) return (op >= 3'b011);
        return (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    endfunction

    // Byte enables of a store before lane shifting; widened by the caller.
    function automatic logic [3:0] get_stmask(input logic [2:0] op);
        case (op)
            ST_SB:   return 4'b0001;
            ST_SH:   return 4'b0011;
            ST_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Brings the addressed bytes down to bit 0 first, so the sign bit is
    // always taken from bit 7 or 15 of the selected data, not of the bus.
    function automatic logic [31:0] get_lddataproc_w(input logic [2:0] op,
                                                     input logic [63:0] rdata,
                                                     input logic [c_OFF_W_MAX-1:0] off);
        logic [31:0] w;
        w = 32'(rdata >> {off, 3'b000});
        case (op)
            LD_LB:   return {{24{w[7]}}, w[7:0]};
            LD_LH:   return {{16{w[15]}}, w[15:0]};
            LD_LW:   return w;
            LD_LBU:  return {24'd0, w[7:0]};
            LD_LHU:  return {16'd0, w[15:0]};
            default: return 32'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_lsu_if.sv
`default_nettype none
// ============================================================================
// Module : rv_lsu_if
// Brief  : Request, data-memory and writeback-response signals of the LSU.
//          master = the load/store unit, slave = pipeline + memory side.
// Rev    : 1.0 - initial release
// ============================================================================
interface rv_lsu_if #(
    parameter int BUS_W = 32
);
    logic               req_valid;
    logic               req_ready;
    logic               req_is_st;
    logic [2:0]         req_fsel;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic [4:0]         req_rd;

    logic               dmem_req_valid;
    logic               dmem_req_ready;
    logic [31:0]        dmem_addr;
    logic [BUS_W/8-1:0] dmem_wmask;
    logic [BUS_W-1:0]   dmem_wdata;
    logic               dmem_rvalid;
    logic [BUS_W-1:0]   dmem_rdata;

    logic               resp_valid;
    logic [4:0]         resp_rd;
    logic [31:0]        resp_data;
    logic               resp_err;

    modport master (
        input  req_valid, req_is_st, req_fsel, req_addr, req_wdata, req_rd,
        output req_ready,
        output dmem_req_valid, dmem_addr, dmem_wmask, dmem_wdata,
        input  dmem_req_ready, dmem_rvalid, dmem_rdata,
        output resp_valid, resp_rd, resp_data, resp_err
    );

    modport slave (
        output req_valid, req_is_st, req_fsel, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  dmem_req_valid, dmem_addr, dmem_wmask, dmem_wdata,
        output dmem_req_ready, dmem_rvalid, dmem_rdata,
        input  resp_valid, resp_rd, resp_data, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/rv_lsu_queue.sv
`default_nettype none
// ============================================================================
// Module : rv_lsu_queue
// Brief  : Generic in-order circular FIFO. Pointers carry one extra wrap bit
//          so full and empty are told apart without a counter.
// Rev    : 1.0 - initial release
// ============================================================================
module rv_lsu_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_PTR_W = $clog2(DEPTH) + 1;

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_IDX_W-1:0] w_widx;
    logic [c_IDX_W-1:0] w_ridx;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push_ok;
    logic               w_pop_ok;

    generate
        if (DEPTH > 1) begin : g_multi
            assign w_widx = r_wptr[c_IDX_W-1:0];
            assign w_ridx = r_rptr[c_IDX_W-1:0];
        end else begin : g_single
            assign w_widx = '0;
            assign w_ridx = '0;
        end
    endgenerate

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[c_PTR_W-1] != r_rptr[c_PTR_W-1]) && (w_widx == w_ridx);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[w_ridx];

    // Pointer update; push and pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Entry storage; contents are don't-care while the slot is free.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[w_widx] <= i_data;
    end
endmodule
`default_nettype wire

// File: rtl/rv_lsu.sv
`default_nettype none
// ============================================================================
// Module : rv_lsu
// Brief  : Pipelined RV32 load/store unit. Aligns store lanes, extracts and
//          extends load data, rejects misaligned/illegal accesses and keeps up
//          to MAX_OUTST memory accesses in flight with in-order completion.
// Rev    : 1.0 - initial release
// ============================================================================
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int BUS_W     = 32,
    parameter int MAX_OUTST = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    rv_lsu_if.master  bus
);
    localparam int c_NB    = BUS_W / 8;
    localparam int c_OFF_W = $clog2(c_NB);

    logic [c_OFF_W-1:0] w_off;
    logic               w_err;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_err_acc;
    lsuQEntry_t         w_enq;
    lsuQEntry_t         w_head;
    logic [31:0]        w_ld_data;

    logic               r_resp_valid;
    logic [4:0]         r_resp_rd;
    logic [31:0]        r_resp_data;
    logic               r_resp_err;

    assign w_off = bus.req_addr[c_OFF_W-1:0];
    assign w_err = get_misaligned(bus.req_fsel, bus.req_is_st, bus.req_addr[1:0])
                || get_illegal(bus.req_fsel, bus.req_is_st);

    // Error requests bypass memory and wait for an empty queue so their
    // response cannot overtake older accesses.
    assign bus.dmem_req_valid = bus.req_valid && !w_err && !w_full;
    assign bus.req_ready      = w_err ? w_empty : (bus.dmem_req_ready && !w_full);

    assign w_push    = bus.dmem_req_valid && bus.dmem_req_ready;
    assign w_pop     = bus.dmem_rvalid && !w_empty;
    assign w_err_acc = bus.req_valid && w_err && w_empty;

    assign bus.dmem_addr  = {bus.req_addr[31:c_OFF_W], {c_OFF_W{1'b0}}};
    assign bus.dmem_wmask = bus.req_is_st ? (c_NB'(get_stmask(bus.req_fsel)) << w_off) : '0;
    assign bus.dmem_wdata = {(BUS_W/32){bus.req_wdata}} << {w_off, 3'b000};

    // Entry recorded at issue; stores carry rd=0 so writeback sees no target.
    always_comb begin
        w_enq       = '0;
        w_enq.rd    = bus.req_is_st ? 5'd0 : bus.req_rd;
        w_enq.fsel  = bus.req_fsel;
        w_enq.off   = c_OFF_W_MAX'(w_off);
        w_enq.is_st = bus.req_is_st;
    end

    rv_lsu_queue #(
        .WIDTH ($bits(lsuQEntry_t)),
        .DEPTH (MAX_OUTST)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_enq),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_ld_data = get_lddataproc_w(w_head.fsel, 64'(bus.dmem_rdata), w_head.off);

    // Writeback register: memory completions and error completions never
    // coincide, since errors are only taken with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rd    <= 5'd0;
            r_resp_data  <= 32'd0;
            r_resp_err   <= 1'b0;
        end else if (w_pop) begin
            r_resp_valid <= 1'b1;
            r_resp_rd    <= w_head.rd;
            r_resp_data  <= w_head.is_st ? 32'd0 : w_ld_data;
            r_resp_err   <= 1'b0;
        end else if (w_err_acc) begin
            r_resp_valid <= 1'b1;
            r_resp_rd    <= bus.req_rd;
            r_resp_data  <= 32'd0;
            r_resp_err   <= 1'b1;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rd    = r_resp_rd;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;

    // Flags a memory response with nothing outstanding; w_pop already drops it.
    always @(posedge clk) begin
        if (!rst && bus.dmem_rvalid) begin
            a_stray_rvalid: assert (!w_empty)
                else $warning("rv_lsu: dmem_rvalid with empty queue dropped");
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rv_lsu.sv
`default_nettype none
// ============================================================================
// Module : tb_rv_lsu
// Brief  : Directed bench for rv_lsu: a 32-bit and a 64-bit instance,
//          hand-computed expected values, immediate-assertion checks.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_rv_lsu;
    import rv_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rv_lsu_if #(.BUS_W(32)) b32 ();
    rv_lsu_if #(.BUS_W(64)) b64 ();

    rv_lsu #(.BUS_W(32), .MAX_OUTST(2)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    rv_lsu #(.BUS_W(64), .MAX_OUTST(2)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req32(input logic st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        b32.req_valid = 1'b1;
        b32.req_is_st = st;
        b32.req_fsel  = f;
        b32.req_addr  = a;
        b32.req_wdata = wd;
        b32.req_rd    = rd;
        #1;
    endtask

    // Issue, accept, then return memory data; returns just after the response edge.
    task automatic load32(input logic [2:0] f, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] rdata);
        req32(1'b0, f, a, 32'd0, rd);
        tick();
        b32.req_valid   = 1'b0;
        b32.dmem_rvalid = 1'b1;
        b32.dmem_rdata  = rdata;
        tick();
        b32.dmem_rvalid = 1'b0;
        #1;
    endtask

    task automatic resp32(input string tag, input logic [4:0] rd, input logic [31:0] d,
                          input logic err);
        chk({tag, ".valid"}, 64'(b32.resp_valid), 64'd1);
        chk({tag, ".rd"},    64'(b32.resp_rd),    64'(rd));
        chk({tag, ".data"},  64'(b32.resp_data),  64'(d));
        chk({tag, ".err"},   64'(b32.resp_err),   64'(err));
    endtask

    initial begin
        b32.req_valid = 0; b32.req_is_st = 0; b32.req_fsel = 3'b000; b32.req_addr = 0;
        b32.req_wdata = 0; b32.req_rd = 0; b32.dmem_req_ready = 1; b32.dmem_rvalid = 0;
        b32.dmem_rdata = 0;
        b64.req_valid = 0; b64.req_is_st = 0; b64.req_fsel = 3'b000; b64.req_addr = 0;
        b64.req_wdata = 0; b64.req_rd = 0; b64.dmem_req_ready = 0; b64.dmem_rvalid = 0;
        b64.dmem_rdata = 0;

        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst.resp_valid", 64'(b32.resp_valid), 64'd0);
        chk("rst.resp_err",   64'(b32.resp_err),   64'd0);
        chk("rst.resp_rd",    64'(b32.resp_rd),    64'd0);
        chk("rst.resp_data",  64'(b32.resp_data),  64'd0);
        chk("rst.req_ready",  64'(b32.req_ready),  64'd1);

        // lw 0x100
        req32(1'b0, LD_LW, 32'h100, 32'd0, 5'd5);
        chk("lw.dmem_valid", 64'(b32.dmem_req_valid), 64'd1);
        chk("lw.dmem_addr",  64'(b32.dmem_addr),      64'h100);
        chk("lw.wmask",      64'(b32.dmem_wmask),     64'h0);
        tick();
        b32.req_valid   = 1'b0;
        b32.dmem_rvalid = 1'b1;
        b32.dmem_rdata  = 32'hDEADBEEF;
        #1;
        chk("lw.resp_early", 64'(b32.resp_valid), 64'd0);
        tick();
        b32.dmem_rvalid = 1'b0;
        resp32("lw", 5'd5, 32'hDEADBEEF, 1'b0);
        tick();
        chk("lw.resp_drop", 64'(b32.resp_valid), 64'd0);

        // Byte and halfword extension at non-zero lane offsets
        req32(1'b0, LD_LB, 32'h103, 32'd0, 5'd6);
        chk("lb.dmem_addr", 64'(b32.dmem_addr), 64'h100);
        load32(LD_LB, 32'h103, 5'd6, 32'h80123456);
        resp32("lb", 5'd6, 32'hFFFFFF80, 1'b0);
        load32(LD_LBU, 32'h103, 5'd7, 32'h80123456);
        resp32("lbu", 5'd7, 32'h00000080, 1'b0);
        load32(LD_LH, 32'h102, 5'd8, 32'h80011234);
        resp32("lh", 5'd8, 32'hFFFF8001, 1'b0);
        load32(LD_LHU, 32'h102, 5'd8, 32'hF00D1234);
        resp32("lhu", 5'd8, 32'h0000F00D, 1'b0);

        // Misaligned lw with empty queue
        req32(1'b0, LD_LW, 32'h102, 32'd0, 5'd9);
        chk("mis.dmem_valid", 64'(b32.dmem_req_valid), 64'd0);
        chk("mis.req_ready",  64'(b32.req_ready),      64'd1);
        tick();
        b32.req_valid = 1'b0;
        resp32("mis", 5'd9, 32'd0, 1'b1);
        tick();
        chk("mis.resp_drop", 64'(b32.resp_valid), 64'd0);

        // Illegal load funct3
        req32(1'b0, 3'b011, 32'h100, 32'd0, 5'd10);
        chk("ill.dmem_valid", 64'(b32.dmem_req_valid), 64'd0);
        tick();
        b32.req_valid = 1'b0;
        resp32("ill", 5'd10, 32'd0, 1'b1);

        // Error request held off while a load is outstanding
        req32(1'b0, LD_LW, 32'h300, 32'd0, 5'd11);
        tick();
        req32(1'b0, LD_LH, 32'h301, 32'd0, 5'd12);
        chk("errq.req_ready",  64'(b32.req_ready),      64'd0);
        chk("errq.dmem_valid", 64'(b32.dmem_req_valid), 64'd0);
        b32.req_valid   = 1'b0;
        b32.dmem_rvalid = 1'b1;
        b32.dmem_rdata  = 32'h12345678;
        tick();
        b32.dmem_rvalid = 1'b0;
        resp32("errq", 5'd11, 32'h12345678, 1'b0);

        // Store lane alignment, then a store completion
        b32.dmem_req_ready = 1'b0;
        req32(1'b1, ST_SB, 32'h301, 32'h000000AB, 5'd0);
        chk("sb.wmask",      64'(b32.dmem_wmask),     64'h2);
        chk("sb.wdata",      64'(b32.dmem_wdata),     64'h0000AB00);
        chk("sb.dmem_valid", 64'(b32.dmem_req_valid), 64'd1);
        chk("sb.req_ready",  64'(b32.req_ready),      64'd0);
        b32.dmem_req_ready = 1'b1;
        req32(1'b1, ST_SW, 32'h300, 32'hCAFEF00D, 5'd3);
        chk("sw.req_ready", 64'(b32.req_ready),  64'd1);
        chk("sw.wmask",     64'(b32.dmem_wmask), 64'hF);
        chk("sw.wdata",     64'(b32.dmem_wdata), 64'hCAFEF00D);
        tick();
        b32.req_valid   = 1'b0;
        b32.dmem_rvalid = 1'b1;
        tick();
        b32.dmem_rvalid = 1'b0;
        resp32("sw", 5'd0, 32'd0, 1'b0);

        // Full queue: no accept even with rvalid in the same cycle
        req32(1'b0, LD_LW, 32'h200, 32'd0, 5'd1);
        tick();
        req32(1'b0, LD_LW, 32'h204, 32'd0, 5'd2);
        tick();
        req32(1'b0, LD_LW, 32'h208, 32'd0, 5'd3);
        b32.dmem_rvalid = 1'b1;
        b32.dmem_rdata  = 32'h11111111;
        #1;
        chk("full.req_ready",  64'(b32.req_ready),      64'd0);
        chk("full.dmem_valid", 64'(b32.dmem_req_valid), 64'd0);
        tick();
        b32.dmem_rvalid = 1'b0;
        #1;
        resp32("full.r1", 5'd1, 32'h11111111, 1'b0);
        chk("full.req_ready2", 64'(b32.req_ready), 64'd1);
        tick();
        b32.req_valid   = 1'b0;
        b32.dmem_rvalid = 1'b1;
        b32.dmem_rdata  = 32'h22222222;
        tick();
        b32.dmem_rdata  = 32'h33333333;
        resp32("b2b.r2", 5'd2, 32'h22222222, 1'b0);
        tick();
        b32.dmem_rvalid = 1'b0;
        resp32("b2b.r3", 5'd3, 32'h33333333, 1'b0);
        tick();
        chk("b2b.idle", 64'(b32.resp_valid), 64'd0);

        // Asynchronous reset with two loads in flight
        req32(1'b0, LD_LW, 32'h500, 32'd0, 5'd20);
        tick();
        req32(1'b0, LD_LW, 32'h504, 32'd0, 5'd21);
        tick();
        b32.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst.resp_valid", 64'(b32.resp_valid), 64'd0);
        chk("arst.req_ready",  64'(b32.req_ready),  64'd1);
        tick();
        rst = 1'b0;
        b32.dmem_rvalid = 1'b1;
        b32.dmem_rdata  = 32'h00000BAD;
        tick();
        b32.dmem_rvalid = 1'b0;
        chk("arst.stray", 64'(b32.resp_valid), 64'd0);
        load32(LD_LW, 32'h400, 5'd7, 32'h0BADF00D);
        resp32("arst.new", 5'd7, 32'h0BADF00D, 1'b0);

        // 64-bit bus: store lanes at offset 6
        b64.req_valid = 1'b1; b64.req_is_st = 1'b1; b64.req_fsel = ST_SH;
        b64.req_addr = 32'h106; b64.req_wdata = 32'h00001234; b64.req_rd = 5'd0;
        #1;
        chk("sh64.dmem_addr",  64'(b64.dmem_addr),      64'h100);
        chk("sh64.wmask",      64'(b64.dmem_wmask),     64'hC0);
        chk("sh64.wdata",      b64.dmem_wdata,          64'h1234_0000_0000_0000);
        chk("sh64.dmem_valid", 64'(b64.dmem_req_valid), 64'd1);

        // 64-bit bus: lh at offset 6, lw at offset 4
        b64.dmem_req_ready = 1'b1;
        b64.req_is_st = 1'b0; b64.req_fsel = LD_LH; b64.req_rd = 5'd3;
        tick();
        b64.req_valid   = 1'b0;
        b64.dmem_rvalid = 1'b1;
        b64.dmem_rdata  = 64'h8001_0000_0000_0000;
        tick();
        b64.dmem_rvalid = 1'b0;
        chk("lh64.valid", 64'(b64.resp_valid), 64'd1);
        chk("lh64.rd",    64'(b64.resp_rd),    64'd3);
        chk("lh64.data",  64'(b64.resp_data),  64'hFFFF8001);
        b64.req_valid = 1'b1; b64.req_fsel = LD_LW; b64.req_addr = 32'h104; b64.req_rd = 5'd4;
        tick();
        b64.req_valid   = 1'b0;
        b64.dmem_rvalid = 1'b1;
        b64.dmem_rdata  = 64'h89AB_CDEF_0123_4567;
        tick();
        b64.dmem_rvalid = 1'b0;
        chk("lw64.rd",   64'(b64.resp_rd),   64'd4);
        chk("lw64.data", 64'(b64.resp_data), 64'h89ABCDEF);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
